// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Pipeline request/response and data-memory bus of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_a, mem_we, mem_wd
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store initiator with sub-word read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input wire logic          clk,
    input wire logic          rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;
    localparam logic [1:0] c_SZ_W = 2'b10;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_a;
    logic        r_mem_we;
    logic [31:0] r_mem_wd;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    always_comb begin
        w_err = 1'b0;
        case (bus.req_funct3)
            3'b011, 3'b110, 3'b111: w_err = 1'b1;
            3'b100, 3'b101:         w_err = bus.req_we;
            default:                w_err = 1'b0;
        endcase
        if (bus.req_funct3[1:0] == c_SZ_H && bus.req_addr[0])
            w_err = 1'b1;
        if (bus.req_funct3[1:0] == c_SZ_W && bus.req_addr[1:0] != 2'b00)
            w_err = 1'b1;
    end

    // Lane extraction and merging work straight off mem_rd during READ.
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = bus.mem_rd[7:0];
            2'd1:    w_byte = bus.mem_rd[15:8];
            2'd2:    w_byte = bus.mem_rd[23:16];
            default: w_byte = bus.mem_rd[31:24];
        endcase
        w_half = r_lane[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

        w_load = bus.mem_rd;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h000000, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0000, w_half};
            default: w_load = bus.mem_rd;
        endcase

        w_merged = bus.mem_rd;
        if (r_funct3[1:0] == c_SZ_B) begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_wdata      <= 16'h0000;
            r_mem_a      <= 32'h0000_0000;
            r_mem_we     <= 1'b0;
            r_mem_wd     <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_lane   <= bus.req_addr[1:0];
                        r_wdata  <= bus.req_wdata[15:0];
                        r_mem_a  <= {bus.req_addr[31:2], 2'b00};
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                        end else if (bus.req_we && bus.req_funct3[1:0] == c_SZ_W) begin
                            r_state  <= S_WRITE;
                            r_mem_we <= 1'b1;
                            r_mem_wd <= bus.req_wdata;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_we) begin
                        r_state  <= S_WRITE;
                        r_mem_we <= 1'b1;
                        r_mem_wd <= w_merged;
                    end else begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load;
                    end
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) && rst;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_a      = r_mem_a;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wd     = r_mem_wd;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    // Word-wide data memory model with a bench-side preload port.
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'h0;

    assign bus.mem_rd = mem[bus.mem_a[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we)
            mem[bus.mem_a[7:2]] <= bus.mem_wd;
        else if (pre_we)
            mem[pre_idx] <= pre_data;
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Presents one request for one cycle; returns at the negedge of T+1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic rdy);
        @(negedge clk);
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        rdy = bus.req_ready;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'hDEAD_BEEF; bus.req_funct3 = 3'b111;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.resp_valid); end
        n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.resp_err); end
        n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        n_tests++; if (bus.mem_wd !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wd: got %h want 0", bus.mem_wd); end
        n_tests++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_mem_a: got %h want 0", bus.mem_a); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
                n_fail++; $display("FAIL idle_quiet: got we=%b valid=%b want 0 0", bus.mem_we, bus.resp_valid);
            end
        end
    endtask

    task automatic test_lw();
        logic rdy;
        preload(6'd2, 32'hAAAA_AAAA);
        issue(1'b0, 3'b010, 32'h0000_0008, 32'h0, rdy);
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL lw_accept: got %b want 1", rdy); end
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_valid_t1: got %b want 0", bus.resp_valid); end
        n_tests++; if (bus.mem_a !== 32'h0000_0008) begin n_fail++; $display("FAIL lw_mem_a: got %h want 00000008", bus.mem_a); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we_t1: got %b want 0", bus.mem_we); end
        @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid_t2: got %b want 1", bus.resp_valid); end
        n_tests++; if (bus.resp_rdata !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL lw_rdata: got %h want aaaaaaaa", bus.resp_rdata); end
        n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", bus.resp_err); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we_t2: got %b want 0", bus.mem_we); end
        @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_valid_t3: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_sb();
        logic rdy;
        preload(6'd3, 32'h5555_5555);
        issue(1'b1, 3'b000, 32'h0000_000D, 32'h1234_5611, rdy);
        n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL sb_accept: got %b want 1", rdy); end
        n_tests++; if (bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL sb_read_t1: got we=%b valid=%b want 0 0", bus.mem_we, bus.resp_valid);
        end
        n_tests++; if (bus.mem_a !== 32'h0000_000C) begin n_fail++; $display("FAIL sb_mem_a: got %h want 0000000c", bus.mem_a); end
        @(negedge clk);
        n_tests++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sb_we_t2: got %b want 1", bus.mem_we); end
        n_tests++; if (bus.mem_wd !== 32'h5555_1155) begin n_fail++; $display("FAIL sb_wd: got %h want 55551155", bus.mem_wd); end
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL sb_valid_t2: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid_t3: got %b want 1", bus.resp_valid); end
        n_tests++; if (bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL sb_resp: got err=%b rdata=%h want 0 00000000", bus.resp_err, bus.resp_rdata);
        end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL sb_we_t3: got %b want 0", bus.mem_we); end
        n_tests++; if (mem[3] !== 32'h5555_1155) begin n_fail++; $display("FAIL sb_mem: got %h want 55551155", mem[3]); end
        issue(1'b0, 3'b010, 32'h0000_000C, 32'h0, rdy);
        @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h5555_1155) begin
            n_fail++; $display("FAIL sb_readback: got valid=%b rdata=%h want 1 55551155", bus.resp_valid, bus.resp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_load_ext();
        logic        rdy;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF};
        preload(6'd4, 32'h80FF_0000);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3s[i], 32'h0000_0012, 32'h0, rdy);
            @(negedge clk);
            n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exps[i] || bus.resp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL ext_f3_%0d: got valid=%b rdata=%h err=%b want 1 %h 0",
                         f3s[i], bus.resp_valid, bus.resp_rdata, bus.resp_err, exps[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_errors();
        logic        rdy;
        logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s   [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] addrs [4] = '{32'h01, 32'h06, 32'h00, 32'h00};
        for (int i = 0; i < 4; i++) begin
            issue(wes[i], f3s[i], addrs[i], 32'hFFFF_FFFF, rdy);
            n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin
                n_fail++; $display("FAIL err_%0d_flag: got valid=%b err=%b want 1 1", i, bus.resp_valid, bus.resp_err);
            end
            n_tests++; if (bus.resp_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
                n_fail++; $display("FAIL err_%0d_quiet: got rdata=%h we=%b want 0 0", i, bus.resp_rdata, bus.mem_we);
            end
            @(negedge clk);
            n_tests++; if (bus.resp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
                n_fail++; $display("FAIL err_%0d_after: got valid=%b we=%b want 0 0", i, bus.resp_valid, bus.mem_we);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic rdy;
        issue(1'b1, 3'b001, 32'h0000_000E, 32'h0000_BEEF, rdy);
        @(negedge clk);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'hBEEF_1155) begin
            n_fail++; $display("FAIL sh_write: got we=%b wd=%h want 1 beef1155", bus.mem_we, bus.mem_wd);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL midrst_quiet: got valid=%b we=%b want 0 0", bus.resp_valid, bus.mem_we);
        end
        n_tests++; if (mem[3] !== 32'hBEEF_1155) begin n_fail++; $display("FAIL midrst_mem: got %h want beef1155", mem[3]); end
        n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", bus.req_ready); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_release: got ready=%b valid=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h20, 32'h24, 32'h28};
        logic [31:0] datas [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        int          acc_c [3] = '{-1, -1, -1};
        int          rsp_c [3] = '{-1, -1, -1};
        logic [31:0] rsp_d [3] = '{32'h0, 32'h0, 32'h0};
        int          exp_acc [3] = '{0, 3, 6};
        int          exp_rsp [3] = '{2, 5, 8};
        int          k = 0;
        int          r = 0;
        logic        accepted;
        for (int i = 0; i < 3; i++) preload(6'(8 + i), datas[i]);
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = addrs[0]; bus.req_valid = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (bus.resp_valid === 1'b1 && r < 3) begin rsp_c[r] = c; rsp_d[r] = bus.resp_rdata; r++; end
            accepted = bus.req_valid && bus.req_ready;
            if (accepted && k < 3) begin acc_c[k] = c; k++; end
            @(posedge clk); #1;
            if (accepted) begin
                if (k < 3) bus.req_addr = addrs[k];
                else bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (acc_c[i] != exp_acc[i]) begin n_fail++; $display("FAIL b2b_acc_%0d: got %0d want %0d", i, acc_c[i], exp_acc[i]); end
            n_tests++; if (rsp_c[i] != exp_rsp[i]) begin n_fail++; $display("FAIL b2b_rsp_%0d: got %0d want %0d", i, rsp_c[i], exp_rsp[i]); end
            n_tests++; if (rsp_d[i] !== datas[i]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", i, rsp_d[i], datas[i]); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_lw();
        test_sb();
        test_load_ext();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator that issues every RV32I load and store (LB/LH/LW/LBU/LHU/SB/SH/SW) to the word-wide data memory. The data memory reads combinationally, writes whole words on the clock edge, and is addressed by addr[31:2]. The block therefore aligns addresses, extracts and sign- or zero-extends load data, and performs a read-modify-write for sub-word stores. It sits between the MEM pipeline stage and the data memory, handshaking with the pipeline through req_valid/req_ready and resp_valid.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  pipeline presents a memory operation.
- req_ready  out  1  block can accept; high only in IDLE with rst high.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte or halfword used for SB/SH.
- resp_valid  out  1  one-cycle pulse; the operation is complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned or illegal funct3.
- mem_a  out  32  word address {addr[31:2], 2'b00}.
- mem_we  out  1  data memory write enable.
- mem_wd  out  32  data memory write data.
- mem_rd  in  32  data memory combinational read data.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - A request is accepted when req_valid && req_ready.
  - On acceptance, latch addr, we, funct3 and wdata.
  - Error check:
    - funct3 011/110/111 is illegal.
    - Store with funct3 100/101 is illegal.
    - H/HU with addr[0]=1 is misaligned.
    - W with addr[1:0]≠0 is misaligned.
  - Error → RESP with err=1; no memory access.
  - Legal load or SB/SH → READ. SW → WRITE.
- READ:
  - mem_a = aligned address, mem_we = 0; capture mem_rd into rbuf.
  - Load → RESP. SB/SH → WRITE.
- WRITE:
  - mem_we = 1, mem_wd = merged word → RESP.
  - SW: merged word = wdata.
  - SB: rbuf with byte lane addr[1:0] (bits 8·lane+7 : 8·lane) replaced by wdata[7:0].
  - SH: rbuf with half addr[1] (bits 16·addr[1]+15 : 16·addr[1]) replaced by wdata[15:0].
- RESP:
  - resp_valid = 1; resp_rdata and resp_err driven from registers → IDLE.
  - LB/LH: selected lane sign-extended. LBU/LHU: zero-extended. LW: rbuf unchanged.
- mem_we is high only in WRITE; mem_a holds the latched aligned address outside IDLE.
- Only one transaction is ever outstanding; there is no queueing.

## Timing
- Acceptance cycle is T. resp_valid is high at:
  - Load: T+2.
  - SW: T+2.
  - SB/SH: T+3. READ at T+1, WRITE at T+2, memory updated at the T+2→T+3 edge.
  - Error: T+1.
- Next acceptance is possible in the cycle after RESP. Back-to-back loads therefore run one per 3 cycles.
- Reset values (after a clock edge with rst=0): state IDLE, req_ready 0 while rst=0, resp_valid 0, resp_err 0, resp_rdata 0, mem_we 0, mem_wd 0, mem_a 0.
- Reset mid-operation:
  - The transaction is dropped and no resp_valid is produced.
  - If the reset edge hits during WRITE, the write in that edge is not suppressed. mem_we is low from the next cycle.
- req_valid deasserted in IDLE: stay in IDLE, no memory activity.
- Request fields are ignored after acceptance; the pipeline may change them freely.

## Test plan
- Preload word 0x08 = 0xAAAA_AAAA; LW addr 0x08 → resp_valid at T+2, resp_rdata 0xAAAA_AAAA, resp_err 0; mem_we never 1.
- Word 0x0C = 0x5555_5555; SB wdata 0x1234_5611 addr 0x0D → READ at T+1, mem_we=1 with mem_wd 0x5555_1155 at T+2, resp_valid at T+3; a following LW 0x0C returns 0x5555_1155.
- Word 0x10 = 0x80FF_0000:
  - LB 0x12 → 0xFFFF_FFFF.
  - LBU 0x12 → 0x0000_00FF.
  - LH 0x12 → 0xFFFF_80FF.
  - LHU 0x12 → 0x0000_80FF.
- Error cases → resp_valid at T+1, resp_err 1, resp_rdata 0, no mem_we:
  - LH addr 0x01.
  - SW addr 0x06.
  - Load funct3 011.
- SH wdata 0xBEEF addr 0x0E with rst driven low in the WRITE cycle → no resp_valid, mem_we 0 the cycle after; after rst returns high, req_ready = 1 on the next cycle.
- req_valid held high with three LWs queued by the bench → accepted at T, T+3, T+6; resp_valid at T+2, T+5, T+8.
